// File: rtl/rapid_recovery_pkg.sv
// Shared definitions for the HMR rapid-recovery path: restore phases and default sizes.
// Used by the recovery scheduler and by the restore datapath it steers.
package rapid_recovery_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    CSR     = 3'd2,
    RF      = 3'd3,
    PC      = 3'd4,
    RELEASE = 3'd5
  } recovery_phase_e;

  localparam int unsigned DefNumGroups = 4;
  localparam int unsigned DefNumCsrs   = 8;
  localparam int unsigned DefNumRfRegs = 32;

  // Index width that stays at least one bit wide for single-entry tables.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hmr_rr_grant.sv
// Combinational round-robin pick: first set request bit at or after ptr_i, wrapping.
// The pointer itself lives in the caller.
module hmr_rr_grant #(
  parameter int unsigned NumGroups = 4,
  parameter int unsigned IdxW      = $clog2(NumGroups)
) (
  input  logic [NumGroups-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NumGroups; off++) begin
      cand     = (32'(ptr_i) + off) % NumGroups;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hmr_recovery_sched.sv
// Rapid-recovery scheduler: grants one DMR group at a time onto the restore path and
// sequences halt, CSR replay, RF replay, PC replay and release for that group.
module hmr_recovery_sched
  import rapid_recovery_pkg::*;
#(
  parameter int unsigned NumGroups = DefNumGroups,
  parameter int unsigned NumCsrs   = DefNumCsrs,
  parameter int unsigned NumRfRegs = DefNumRfRegs,
  parameter int unsigned GrpIdxW   = $clog2(NumGroups),
  parameter int unsigned CsrAddrW  = idx_w(NumCsrs),
  parameter int unsigned RfAddrW   = idx_w(NumRfRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumGroups-1:0] recovery_request_i,
  input  logic [NumGroups-1:0] cores_halted_i,
  output logic [NumGroups-1:0] recovery_finished_o,
  output logic [NumGroups-1:0] setback_o,
  output logic                 busy_o,
  output logic [GrpIdxW-1:0]   grp_sel_o,
  output logic                 csr_we_o,
  output logic [CsrAddrW-1:0]  csr_addr_o,
  input  logic                 csr_ready_i,
  output logic                 rf_we_o,
  output logic [RfAddrW-1:0]   rf_addr_o,
  input  logic                 rf_ready_i,
  output logic                 pc_we_o,
  input  logic                 pc_ready_i
);

  // Handshake: a restore write transfers in any cycle where *_we_o and *_ready_i are
  // both high; while ready is low, valid and address hold their values.

  recovery_phase_e state_q, state_d;
  logic [GrpIdxW-1:0]  grp_q, grp_d;
  logic [GrpIdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CsrAddrW-1:0] csr_cnt_q, csr_cnt_d;
  logic [RfAddrW-1:0]  rf_cnt_q, rf_cnt_d;

  logic [GrpIdxW-1:0] gnt_idx;
  logic               gnt_valid;

  hmr_rr_grant #(
    .NumGroups (NumGroups),
    .IdxW      (GrpIdxW)
  ) u_rr_grant (
    .req_i   (recovery_request_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      rr_ptr_q  <= '0;
      csr_cnt_q <= '0;
      rf_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      rr_ptr_q  <= rr_ptr_d;
      csr_cnt_q <= csr_cnt_d;
      rf_cnt_q  <= rf_cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    grp_d               = grp_q;
    rr_ptr_d            = rr_ptr_q;
    csr_cnt_d           = csr_cnt_q;
    rf_cnt_d            = rf_cnt_q;
    setback_o           = '0;
    recovery_finished_o = '0;
    csr_we_o            = 1'b0;
    rf_we_o             = 1'b0;
    pc_we_o             = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grp_d    = gnt_idx;
          rr_ptr_d = (gnt_idx == GrpIdxW'(NumGroups - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = HALT;
        end
      end
      HALT: begin
        setback_o[grp_q] = 1'b1;
        if (cores_halted_i[grp_q]) state_d = CSR;
      end
      CSR: begin
        setback_o[grp_q] = 1'b1;
        csr_we_o         = 1'b1;
        // Leaving the phase wins over incrementing, so the index never wraps.
        if (csr_ready_i) begin
          if (csr_cnt_q == CsrAddrW'(NumCsrs - 1)) begin
            csr_cnt_d = '0;
            state_d   = RF;
          end else begin
            csr_cnt_d = csr_cnt_q + 1'b1;
          end
        end
      end
      RF: begin
        setback_o[grp_q] = 1'b1;
        rf_we_o          = 1'b1;
        if (rf_ready_i) begin
          if (rf_cnt_q == RfAddrW'(NumRfRegs - 1)) begin
            rf_cnt_d = '0;
            state_d  = PC;
          end else begin
            rf_cnt_d = rf_cnt_q + 1'b1;
          end
        end
      end
      PC: begin
        setback_o[grp_q] = 1'b1;
        pc_we_o          = 1'b1;
        if (pc_ready_i) state_d = RELEASE;
      end
      RELEASE: begin
        recovery_finished_o[grp_q] = 1'b1;
        state_d                    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign grp_sel_o  = grp_q;
  assign csr_addr_o = csr_cnt_q;
  assign rf_addr_o  = rf_cnt_q;

endmodule

// File: tb/tb_hmr_recovery_sched.sv
// Scoreboard bench for hmr_recovery_sched: the driver pushes hand-timed restore events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_hmr_recovery_sched;

  localparam int NG = 4;
  localparam int NC = 8;
  localparam int NR = 32;

  localparam int K_HALT = 1;
  localparam int K_CSR  = 2;
  localparam int K_RF   = 3;
  localparam int K_PC   = 4;
  localparam int K_FIN  = 5;
  localparam int K_SBF  = 6;

  logic          clk;
  logic          rst;
  logic [NG-1:0] req;
  logic [NG-1:0] halted;
  logic [NG-1:0] finished;
  logic [NG-1:0] setback;
  logic          busy;
  logic [1:0]    grp_sel;
  logic          csr_we;
  logic [2:0]    csr_addr;
  logic          csr_ready;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic          rf_ready;
  logic          pc_we;
  logic          pc_ready;

  hmr_recovery_sched dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .recovery_request_i  (req),
    .cores_halted_i      (halted),
    .recovery_finished_o (finished),
    .setback_o           (setback),
    .busy_o              (busy),
    .grp_sel_o           (grp_sel),
    .csr_we_o            (csr_we),
    .csr_addr_o          (csr_addr),
    .csr_ready_i         (csr_ready),
    .rf_we_o             (rf_we),
    .rf_addr_o           (rf_addr),
    .rf_ready_i          (rf_ready),
    .pc_we_o             (pc_we),
    .pc_ready_i          (pc_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  logic [31:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  bit  done     = 1'b0;
  bit  bp_en    = 1'b0;
  int  idle_chk_cyc = -1;

  function automatic logic [31:0] ev(input int kind, input int grp, input int idx, input int c);
    return {4'(kind), 4'(grp), 8'(idx), 16'(c)};
  endfunction

  function automatic int oh_idx(input logic [NG-1:0] v);
    for (int i = 0; i < NG; i++) if (v[i]) return i;
    return 15;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // Expected events of one full restore granted at IDLE cycle t.
  task automatic push_restore(input int grp, input int t, input int csr_start, input bit rf_bp);
    int c;
    int idx;
    exp_q.push_back(ev(K_HALT, grp, 0, t + 1));
    c = csr_start;
    for (int i = 0; i < NC; i++) begin
      exp_q.push_back(ev(K_CSR, grp, i, c));
      c++;
    end
    idx = 0;
    while (idx < NR) begin
      if (!rf_bp || (c % 2 == 0)) begin
        exp_q.push_back(ev(K_RF, grp, idx, c));
        idx++;
      end
      c++;
    end
    exp_q.push_back(ev(K_PC, grp, 0, c));
    exp_q.push_back(ev(K_FIN, grp, 0, c + 1));
    exp_q.push_back(ev(K_SBF, grp, 0, c + 1));
  endtask

  // rf_ready low on odd cycles while backpressure is enabled
  initial begin
    rf_ready = 1'b1;
    forever begin
      step();
      rf_ready = bp_en ? (cyc % 2 == 0) : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int t2;
    rst       = 1'b1;
    req       = '0;
    halted    = '1;
    csr_ready = 1'b1;
    pc_ready  = 1'b1;
    step();
    step();
    step();
    rst          = 1'b0;
    idle_chk_cyc = cyc;
    mon_en       = 1'b1;

    // single request, group 2, everything ready
    step();
    t   = cyc;
    req = 4'b0100;
    push_restore(2, t, t + 2, 1'b0);
    step();
    req = '0;
    wait_idle();

    // group 1 cores halt 10 cycles after grant
    step();
    t      = cyc;
    halted = 4'b1101;
    req    = 4'b0010;
    push_restore(1, t, t + 12, 1'b0);
    step();
    req = '0;
    wait_until(t + 11);
    halted = '1;
    wait_idle();

    // group 0 with RF backpressure on alternating cycles
    step();
    t     = cyc;
    bp_en = 1'b1;
    req   = 4'b0001;
    push_restore(0, t, t + 2, 1'b1);
    step();
    req = '0;
    wait_idle();
    bp_en = 1'b0;

    // group 3 drops its request in the RF phase
    step();
    t   = cyc;
    req = 4'b1000;
    push_restore(3, t, t + 2, 1'b0);
    wait_until(t + 20);
    req = '0;
    wait_idle();

    // reset during CSR phase of group 1, then a four-way tie
    step();
    t   = cyc;
    req = 4'b0010;
    exp_q.push_back(ev(K_HALT, 1, 0, t + 1));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(K_CSR, 1, i, t + 2 + i));
    exp_q.push_back(ev(K_SBF, 1, 0, t + 5));
    step();
    req = '0;
    wait_until(t + 4);
    rst = 1'b1;
    step();
    rst          = 1'b0;
    idle_chk_cyc = cyc;
    step();
    t2  = cyc;
    req = 4'b1111;
    push_restore(0, t2, t2 + 2, 1'b0);
    step();
    req = '0;
    wait_idle();

    // round-robin fairness: all groups request continuously from reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    t   = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_restore(k % NG, t + 44 * k, t + 44 * k + 2, 1'b0);
    wait_until(t + 4 * 44 + 2);
    req = '0;
    wait_idle();

    step();
    step();
    done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [NG-1:0] prev_sb     = '0;
  bit            rf_hold_pend = 1'b0;
  logic [4:0]    rf_hold_addr = '0;
  int            busy_run     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d grp=%0d idx=%0d cyc=%0d expected no event",
               name, act[31:28], act[27:24], act[23:16], act[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d grp=%0d idx=%0d cyc=%0d expected kind=%0d grp=%0d idx=%0d cyc=%0d",
                 name, act[31:28], act[27:24], act[23:16], act[15:0],
                 e[31:28], e[27:24], e[23:16], e[15:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_at_most_one", 64'($onehot0({csr_we, rf_we, pc_we})), 64'd1);
      chk("setback_onehot0", 64'($onehot0(setback)), 64'd1);
      chk("finished_onehot0", 64'($onehot0(finished)), 64'd1);

      if (cyc == idle_chk_cyc)
        chk("reset_outputs_zero",
            64'({finished, setback, busy, grp_sel, csr_we, csr_addr, rf_we, rf_addr, pc_we}), 64'd0);

      if (rf_hold_pend) chk("rf_addr_hold", 64'({rf_we, rf_addr}), 64'({1'b1, rf_hold_addr}));
      rf_hold_pend = rf_we && !rf_ready;
      rf_hold_addr = rf_addr;

      if (setback != '0 && prev_sb == '0) sb_pop("halt_start", ev(K_HALT, oh_idx(setback), 0, cyc));
      if (csr_we && csr_ready) sb_pop("csr_write", ev(K_CSR, int'(grp_sel), int'(csr_addr), cyc));
      if (rf_we && rf_ready) sb_pop("rf_write", ev(K_RF, int'(grp_sel), int'(rf_addr), cyc));
      if (pc_we && pc_ready) sb_pop("pc_write", ev(K_PC, int'(grp_sel), 0, cyc));
      if (finished != '0) sb_pop("finished", ev(K_FIN, oh_idx(finished), 0, cyc));
      if (setback == '0 && prev_sb != '0) sb_pop("setback_fall", ev(K_SBF, oh_idx(prev_sb), 0, cyc));
      prev_sb = setback;

      if (busy) begin
        busy_run++;
        if (busy_run == 151) chk("restore_stuck", 64'(busy_run), 64'd150);
      end else begin
        if (busy_run > 0) chk("restore_length_bounded", 64'(busy_run <= 150), 64'd1);
        busy_run = 0;
      end

      if (done) begin
        chk("expected_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
    if (cyc > 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got cycle %0d expected below 20000", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

endmodule
